// File: rtl/axil_master_if.sv
// axil_master_if: single-outstanding AXI4-Lite initiator behind a cmd/rsp valid-ready port.
// Define AXIL_MST_TIMEOUT_EN to add a per-phase watchdog that answers with SLVERR after TIMEOUT_CYCLES.
module axil_master_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp
);
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
  state_t state, state_nx;
  logic accept, wr_done, b_hs, r_hs, tmo;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RSP;
  assign bready    = state == WR_B;
  assign rready    = state == RD_R;
  assign accept    = cmd_valid && cmd_ready;
  assign b_hs      = bvalid && bready;
  assign r_hs      = rvalid && rready;
  // a low valid inside WR_AW_W means that channel already handshook
  assign wr_done   = (!awvalid || awready) && (!wvalid || wready);
`ifdef AXIL_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state_nx != state) ? '0 : cnt + CW'(1);
  assign tmo = (state inside {WR_AW_W, WR_B, RD_AR, RD_R}) && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) rsp_timeout <= 1'b0;
    else if (b_hs || r_hs) rsp_timeout <= 1'b0;
    else if (tmo && state_nx == RSP) rsp_timeout <= 1'b1;
`else
  assign tmo = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (cmd_we ? WR_AW_W : RD_AR) : IDLE;
      WR_AW_W: state_nx = wr_done ? WR_B : tmo ? RSP : WR_AW_W;
      WR_B:    state_nx = (bvalid || tmo) ? RSP : WR_B;
      RD_AR:   state_nx = arready ? RD_R : tmo ? RSP : RD_AR;
      RD_R:    state_nx = (rvalid || tmo) ? RSP : RD_R;
      RSP:     state_nx = rsp_ready ? IDLE : RSP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      awvalid <= (accept && cmd_we) || (awvalid && !awready && !tmo);
      wvalid  <= (accept && cmd_we) || (wvalid && !wready && !tmo);
      arvalid <= (accept && !cmd_we) || (arvalid && !arready && !tmo);
      if (accept && cmd_we) begin
        awaddr <= cmd_addr;
        wdata  <= cmd_wdata;
        wstrb  <= cmd_wstrb;
      end
      if (accept && !cmd_we) araddr <= cmd_addr;
      if (b_hs) rsp_resp <= bresp;
      else if (r_hs) {rsp_rdata, rsp_resp} <= {rdata, rresp};
      else if (tmo && state_nx == RSP) rsp_resp <= 2'b10;
    end
endmodule
